instr_prefetch_reg: RTL and testbench

Parametrised instruction register with a small prefetch queue, sitting between the memory data bus and the CPU controller. It accepts instruction words from memory, buffers up to DEPTH of them behind a holding instruction register (IR), and presents the decoded opcode and address fields of the current instruction. The controller consumes instructions with a valid/advance handshake and discards buffered words with a flush on branch or jump.

---
 rtl/instr_prefetch_reg.sv | 110 +++++++++++
 tb/tb_instr_prefetch_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_reg.sv
// Instruction register fronted by a DEPTH-entry circular prefetch queue.
// The IR refills from the queue head, or directly from memory when the queue is empty.
module instr_prefetch_reg #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          mdata_in,
  input  logic                       mdata_valid,
  output logic                       fetch_ready,
  input  logic                       ir_advance,
  input  logic                       flush,
  output logic                       ir_valid,
  output logic [OP_W-1:0]            op_out,
  output logic [ADDR_W-1:0]          ir_addr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow_err
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  if (DATA_W != OP_W + ADDR_W) begin : g_width_check
    $error("instr_prefetch_reg: DATA_W must equal OP_W + ADDR_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("instr_prefetch_reg: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] head_word;
  logic              wr_acc;
  logic              ir_free;
  logic              pop;
  logic              bypass;
  logic              push;
  logic [LVL_W-1:0]  level_nxt;

  assign fetch_ready = (level < FULL);
  assign head_word   = mem[rd_ptr];

  // An empty queue with a free IR lets the incoming word skip the queue entirely.
  always_comb begin
    wr_acc    = mdata_valid && fetch_ready;
    ir_free   = !ir_valid || ir_advance;
    pop       = ir_free && (level != '0);
    bypass    = ir_free && (level == '0) && wr_acc;
    push      = wr_acc && !bypass;
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (!push && pop) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= mdata_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_valid     <= 1'b0;
      op_out       <= '0;
      ir_addr      <= '0;
      level        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
      level    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (mdata_valid && !fetch_ready) begin
        overflow_err <= 1'b1;
      end
      if (ir_free) begin
        if (pop) begin
          op_out   <= head_word[DATA_W-1 -: OP_W];
          ir_addr  <= head_word[ADDR_W-1:0];
          ir_valid <= 1'b1;
        end else if (wr_acc) begin
          op_out   <= mdata_in[DATA_W-1 -: OP_W];
          ir_addr  <= mdata_in[ADDR_W-1:0];
          ir_valid <= 1'b1;
        end else begin
          ir_valid <= 1'b0;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_reg.sv
// Scoreboard bench: the model is an in-order list of held words (IR first, then queue).
module tb_instr_prefetch_reg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] mdata_in;
  logic              mdata_valid;
  logic              fetch_ready;
  logic              ir_advance;
  logic              flush;
  logic              ir_valid;
  logic [OP_W-1:0]   op_out;
  logic [ADDR_W-1:0] ir_addr;
  logic [LW-1:0]     level;
  logic              overflow_err;

  instr_prefetch_reg #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mdata_in    (mdata_in),
    .mdata_valid (mdata_valid),
    .fetch_ready (fetch_ready),
    .ir_advance  (ir_advance),
    .flush       (flush),
    .ir_valid    (ir_valid),
    .op_out      (op_out),
    .ir_addr     (ir_addr),
    .level       (level),
    .overflow_err(overflow_err)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit ovf_m = 1'b0;
  bit done  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic int model_level();
    return (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
  endfunction

  // One clock cycle of stimulus; model updated after the edge that consumed it.
  task automatic cyc(input bit mv, input logic [DATA_W-1:0] d, input bit adv, input bit fl);
    bit fr;
    fr          = model_level() < DEPTH;
    mdata_valid = mv;
    mdata_in    = d;
    ir_advance  = adv;
    flush       = fl;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else if (mv && fr) exp_q.push_back(d);
    if (mv && !fr && !fl) ovf_m = 1'b1;
  endtask

  function automatic int ir_word();
    return int'({op_out, ir_addr});
  endfunction

  // Monitor: compares visible state, pops the head when the controller consumes it.
  always @(negedge clk) begin
    if (rst && !done) begin
      chk("level", int'(level), model_level());
      chk("fetch_ready", int'(fetch_ready), int'(model_level() < DEPTH));
      chk("overflow_err", int'(overflow_err), int'(ovf_m));
      chk("ir_valid", int'(ir_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("ir_word", ir_word(), int'(exp_q[0]));
        if (ir_advance && !flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && exp_q.size() > 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] word;
    rst = 1'b0; mdata_in = '0; mdata_valid = 1'b0; ir_advance = 1'b0; flush = 1'b0;
    #23 rst = 1'b1;
    @(posedge clk); #1;

    // single load
    cyc(1'b1, 8'hA7, 1'b0, 1'b0);
    chk("single_op", int'(op_out), 5);
    chk("single_addr", int'(ir_addr), 7);
    chk("single_valid", int'(ir_valid), 1);
    chk("single_level", int'(level), 0);
    drain();

    // bypass stream
    cyc(1'b1, 8'h20, 1'b1, 1'b0);
    chk("bypass_20", ir_word(), 'h20);
    cyc(1'b1, 8'h41, 1'b1, 1'b0);
    chk("bypass_41", ir_word(), 'h41);
    chk("bypass_lvl", int'(level), 0);
    cyc(1'b1, 8'h62, 1'b1, 1'b0);
    chk("bypass_62", ir_word(), 'h62);
    chk("bypass_lvl2", int'(level), 0);
    drain();

    // flush collision
    for (int i = 1; i <= 3; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
    chk("pre_flush_level", int'(level), 2);
    cyc(1'b1, 8'hFF, 1'b1, 1'b1);
    chk("flush_valid", int'(ir_valid), 0);
    chk("flush_level", int'(level), 0);
    chk("flush_ovf", int'(overflow_err), 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("flush_dropped", int'(ir_valid), 0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    chk("post_flush_word", ir_word(), 'h33);
    drain();

    // fill and overflow
    for (int i = 1; i <= 6; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
    chk("fill_ir", ir_word(), 'h01);
    chk("fill_level", int'(level), 4);
    chk("fill_ready", int'(fetch_ready), 0);
    chk("fill_ovf", int'(overflow_err), 1);
    for (int i = 1; i <= 5; i++) begin
      chk("fill_order", ir_word(), i);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("fill_empty", int'(ir_valid), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(8'h50 + i), 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 3);
    chk("pre_rst_valid", int'(ir_valid), 1);
    mdata_valid = 1'b0; ir_advance = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_op", int'(op_out), 0);
    chk("rst_addr", int'(ir_addr), 0);
    chk("rst_valid", int'(ir_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(fetch_ready), 1);
    chk("rst_ovf", int'(overflow_err), 0);
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // pointer wrap with a shallow steady queue
    cyc(1'b1, 8'h80, 1'b0, 1'b0);
    cyc(1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 2; i < 2 + 3 * DEPTH; i++) begin
      cyc(1'b1, DATA_W'(8'h80 + i), 1'b1, 1'b0);
      chk("wrap_level", int'(level), 1);
    end
    drain();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      word = DATA_W'($urandom);
      cyc(($urandom_range(0, 3) != 0), word, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 31) == 0));
    end
    drain();

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
